// File: rtl/reg_datapath_pkg.sv
// Shared encodings for the register datapath and the sequencing controller that drives it.
// ALU op-codes, source-bus selects and register write masks.
package reg_datapath_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] SEL_ZERO   = 2'b00;
    localparam logic [1:0] SEL_SW     = 2'b01;
    localparam logic [1:0] SEL_R3     = 2'b10;
    localparam logic [1:0] SEL_CUSTOM = 2'b11;

    localparam logic [2:0] WR_R1  = 3'b001;
    localparam logic [2:0] WR_R2  = 3'b010;
    localparam logic [2:0] WR_R3  = 3'b100;
    localparam logic [2:0] WR_ALL = 3'b111;

endpackage

// File: rtl/reg_datapath_alu4.sv
// Combinational ALU: add (with carry-out), xor, or, and not-a.
// Carry-out is only meaningful for add and is forced low otherwise.
module alu4
    import reg_datapath_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        // NOTE: defaults come first so every path assigns y and cout; no latch can be inferred.
        y    = sum[WIDTH-1:0];
        cout = 1'b0;
        case (op)
            ALU_ADD: cout = sum[WIDTH];
            ALU_XOR: y    = a ^ b;
            ALU_OR:  y    = a | b;
            ALU_NOT: y    = ~a;
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_datapath.sv
// Three-register datapath: source mux feeds R1/R2, the ALU feeds R3, one transfer per clock.
// Also holds the switch synchronizer, registered ALU flags and a saturating write counter.
module reg_datapath
    import reg_datapath_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic [2:0]       wr_reg,
    input  logic [1:0]       data_path_select,
    input  logic [WIDTH-1:0] data_path_custom,
    input  logic [1:0]       alu_op_code,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic [CNT_W-1:0] wr_count
);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic             carry_q, carry_d, zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;

    alu4 #(.WIDTH(WIDTH)) u_alu (
        .a    (r1_q),
        .b    (r2_q),
        .op   (alu_op_code),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        bus = '0;
        case (data_path_select)
            SEL_ZERO:   bus = '0;
            SEL_SW:     bus = s2_q;
            SEL_R3:     bus = r3_q;
            SEL_CUSTOM: bus = data_path_custom;
            default:    bus = '0;
        endcase
    end

    // R3 only ever loads from the ALU; the flags follow R3 writes and hold otherwise.
    always_comb begin
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        if (|(wr_reg & WR_R1)) r1_d = bus;
        if (|(wr_reg & WR_R2)) r2_d = bus;
        if (|(wr_reg & WR_R3)) begin
            r3_d    = alu_y;
            carry_d = alu_cout;
            zero_d  = (alu_y == '0);
        end
        if ((wr_reg != 3'b000) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values in parallel.
            s1_q    <= sw;
            s2_q    <= s1_q;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign r1       = r1_q;
    assign r2       = r2_q;
    assign r3       = r3_q;
    assign alu_out  = alu_y;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_datapath.sv
// Scoreboard bench for reg_datapath: directed steps push hand-computed register state,
// a negedge monitor pops and compares; a CNT_W=2 copy shares the inputs to exercise saturation.
module tb_reg_datapath;
    import reg_datapath_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw, custom;
    logic [2:0] wr;
    logic [1:0] sel, op;

    logic [3:0] r1, r2, r3, alu_out;
    logic       carry, zero;
    logic [7:0] wr_count;
    logic [3:0] s_r1, s_r2, s_r3, s_alu_out;
    logic       s_carry, s_zero;
    logic [1:0] s_wr_count;

    reg_datapath #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sw(sw), .wr_reg(wr), .data_path_select(sel),
        .data_path_custom(custom), .alu_op_code(op), .r1(r1), .r2(r2), .r3(r3),
        .alu_out(alu_out), .carry(carry), .zero(zero), .wr_count(wr_count)
    );

    reg_datapath #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .sw(sw), .wr_reg(wr), .data_path_select(sel),
        .data_path_custom(custom), .alu_op_code(op), .r1(s_r1), .r2(s_r2), .r3(s_r3),
        .alu_out(s_alu_out), .carry(s_carry), .zero(s_zero), .wr_count(s_wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] r1, r2, r3;
        logic       c, z;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of controls, then queue the state expected after that edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] w,
                        input logic [1:0] s, input logic [3:0] cst, input logic [1:0] o,
                        input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                        input logic ec, input logic ez, input logic [7:0] ecnt);
        exp_t e;
        reset = rst; wr = w; sel = s; custom = cst; op = o;
        @(posedge clk);
        #1;
        e.tag = tag; e.r1 = e1; e.r2 = e2; e.r3 = e3; e.c = ec; e.z = ez; e.cnt = ecnt;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Idle cycle, then a direct look at the combinational ALU output.
    task automatic probe(input string tag, input logic [1:0] o, input logic [3:0] exp_y);
        reset = 1'b0; wr = 3'b000; op = o;
        @(posedge clk);
        @(negedge clk);
        check(tag, alu_out, exp_y);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".r1"}, r1, e.r1);
            check({e.tag, ".r2"}, r2, e.r2);
            check({e.tag, ".r3"}, r3, e.r3);
            check({e.tag, ".carry"}, carry, e.c);
            check({e.tag, ".zero"}, zero, e.z);
            check({e.tag, ".wr_count"}, wr_count, e.cnt);
            check({e.tag, ".sat_count"}, s_wr_count, (e.cnt > 8'd3) ? 32'd3 : 32'(e.cnt));
        end
    end

    initial begin
        int c;
        reset = 1'b1; sw = 4'h5; custom = 4'h0; wr = 3'b000; sel = SEL_ZERO; op = ALU_ADD;

        step("rst0", 1, 3'b000, SEL_ZERO,   4'h0, ALU_ADD, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0);
        step("pre1", 0, 3'b011, SEL_CUSTOM, 4'hA, ALU_ADD, 4'hA, 4'hA, 4'h0, 0, 0, 8'd1);
        step("pre2", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_ADD, 4'hA, 4'hA, 4'h4, 1, 0, 8'd2);
        step("rst1", 1, WR_ALL, SEL_CUSTOM, 4'hF, ALU_ADD, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0);
        step("idl1", 0, 3'b000, SEL_ZERO,   4'h0, ALU_ADD, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0);
        step("idl2", 0, 3'b000, SEL_ZERO,   4'h0, ALU_ADD, 4'h0, 4'h0, 4'h0, 0, 0, 8'd0);

        step("seq1", 0, WR_R1,  SEL_SW,     4'h0, ALU_ADD, 4'h5, 4'h0, 4'h0, 0, 0, 8'd1);
        step("seq2", 0, WR_R2,  SEL_CUSTOM, 4'h3, ALU_ADD, 4'h5, 4'h3, 4'h0, 0, 0, 8'd2);
        step("seq3", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_ADD, 4'h5, 4'h3, 4'h8, 0, 0, 8'd3);
        step("seq4", 0, WR_R2,  SEL_R3,     4'h0, ALU_ADD, 4'h5, 4'h8, 4'h8, 0, 0, 8'd4);
        step("seq5", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_OR,  4'h5, 4'h8, 4'hD, 0, 0, 8'd5);
        step("seq6", 0, WR_R1,  SEL_R3,     4'h0, ALU_OR,  4'hD, 4'h8, 4'hD, 0, 0, 8'd6);
        step("seq7", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_NOT, 4'hD, 4'h8, 4'h2, 0, 0, 8'd7);
        step("seq8", 0, WR_R1,  SEL_R3,     4'h0, ALU_NOT, 4'h2, 4'h8, 4'h2, 0, 0, 8'd8);
        step("seq9", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_XOR, 4'h2, 4'h8, 4'hA, 0, 0, 8'd9);

        step("ovf1", 0, WR_R1,  SEL_CUSTOM, 4'hF, ALU_ADD, 4'hF, 4'h8, 4'hA, 0, 0, 8'd10);
        step("ovf2", 0, WR_R2,  SEL_CUSTOM, 4'h3, ALU_ADD, 4'hF, 4'h3, 4'hA, 0, 0, 8'd11);
        probe("alu_add", ALU_ADD, 4'h2);
        probe("alu_xor", ALU_XOR, 4'hC);
        probe("alu_or",  ALU_OR,  4'hF);
        probe("alu_not", ALU_NOT, 4'h0);
        step("ovf3", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_ADD, 4'hF, 4'h3, 4'h2, 1, 0, 8'd12);
        step("ovf4", 0, WR_R2,  SEL_CUSTOM, 4'hF, ALU_ADD, 4'hF, 4'hF, 4'h2, 1, 0, 8'd13);
        step("ovf5", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_XOR, 4'hF, 4'hF, 4'h0, 0, 1, 8'd14);

        step("zer1", 0, 3'b011, SEL_CUSTOM, 4'h5, ALU_ADD, 4'h5, 4'h5, 4'h0, 0, 1, 8'd15);
        step("zer2", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_ADD, 4'h5, 4'h5, 4'hA, 0, 0, 8'd16);
        step("zer3", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_XOR, 4'h5, 4'h5, 4'h0, 0, 1, 8'd17);
        sw = 4'h0;
        step("hld1", 0, 3'b000, SEL_ZERO,   4'h0, ALU_ADD, 4'h5, 4'h5, 4'h0, 0, 1, 8'd17);
        step("hld2", 0, 3'b000, SEL_ZERO,   4'h0, ALU_OR,  4'h5, 4'h5, 4'h0, 0, 1, 8'd17);
        step("hld3", 0, 3'b000, SEL_ZERO,   4'h0, ALU_NOT, 4'h5, 4'h5, 4'h0, 0, 1, 8'd17);

        step("syn0", 0, WR_R1,  SEL_ZERO,   4'h0, ALU_ADD, 4'h0, 4'h5, 4'h0, 0, 1, 8'd18);
        sw = 4'h9;
        step("syn1", 0, WR_R1,  SEL_SW,     4'h0, ALU_ADD, 4'h0, 4'h5, 4'h0, 0, 1, 8'd19);
        step("syn2", 0, WR_R1,  SEL_SW,     4'h0, ALU_ADD, 4'h0, 4'h5, 4'h0, 0, 1, 8'd20);
        step("syn3", 0, WR_R1,  SEL_SW,     4'h0, ALU_ADD, 4'h9, 4'h5, 4'h0, 0, 1, 8'd21);

        step("par1", 0, WR_R1,  SEL_CUSTOM, 4'h5, ALU_ADD, 4'h5, 4'h5, 4'h0, 0, 1, 8'd22);
        step("par2", 0, WR_R2,  SEL_CUSTOM, 4'h2, ALU_ADD, 4'h5, 4'h2, 4'h0, 0, 1, 8'd23);
        step("par3", 0, WR_R3,  SEL_ZERO,   4'h0, ALU_ADD, 4'h5, 4'h2, 4'h7, 0, 0, 8'd24);
        step("par4", 0, WR_R1,  SEL_CUSTOM, 4'h1, ALU_ADD, 4'h1, 4'h2, 4'h7, 0, 0, 8'd25);
        step("par5", 0, 3'b101, SEL_R3,     4'h0, ALU_ADD, 4'h7, 4'h2, 4'h3, 0, 0, 8'd26);
        step("par6", 0, WR_ALL, SEL_ZERO,   4'h0, ALU_XOR, 4'h0, 4'h0, 4'h5, 0, 0, 8'd27);

        // Drive the 8-bit counter past its ceiling; it must stick at 255.
        c = 27;
        for (int i = 0; i < 232; i++) begin
            c = (c < 255) ? c + 1 : 255;
            step("sat", 0, WR_R2, SEL_ZERO, 4'h0, ALU_XOR, 4'h0, 4'h0, 4'h5, 0, 0, 8'(c));
        end
        wr = 3'b000;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
